vga_sync_gen: RTL

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

---
 rtl/vga_sync_gen.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/vga_sync_gen.sv
// 640x480@60 VGA sync generator: pixel counters, H/V phase FSMs, registered syncs,
// blanked colors and a frame tick/counter. Optional colour-bar pattern under VGA_TEST_PATTERN_EN.
module vga_sync_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk25,
    input  logic       Reset,
    input  logic [2:0] red,
    input  logic [2:0] green,
    input  logic [1:0] blue,
    input  logic       test_sel,
    output logic [9:0] xpos,
    output logic [9:0] ypos,
    output logic       hsync,
    output logic       vsync,
    output logic [2:0] vga_red,
    output logic [2:0] vga_green,
    output logic [1:0] vga_blue,
    output logic       frame_tick,
    output logic [7:0] frame_count
);

    localparam logic [9:0] H_FP_START   = 10'(H_ACTIVE);
    localparam logic [9:0] H_SYNC_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_BP_START   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] H_LAST       = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_FP_START   = 10'(V_ACTIVE);
    localparam logic [9:0] V_SYNC_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_BP_START   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] V_LAST       = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    localparam logic [1:0] ACTIVE = 2'd0;
    localparam logic [1:0] FRONT  = 2'd1;
    localparam logic [1:0] SYNC   = 2'd2;
    localparam logic [1:0] BACK   = 2'd3;

    logic [1:0] h_state;
    logic [1:0] v_state;
    logic       line_end;
    logic [2:0] pix_red;
    logic [2:0] pix_green;
    logic [1:0] pix_blue;

    assign line_end = (xpos == H_LAST);

    always_ff @(posedge clk25) begin
        if (Reset) begin
            xpos <= '0;
            ypos <= '0;
        end else if (line_end) begin
            xpos <= '0;
            ypos <= (ypos == V_LAST) ? '0 : ypos + 10'd1;
        end else begin
            xpos <= xpos + 10'd1;
        end
    end

    // Phase FSMs advance on the last count of each phase, so state always matches the counters.
    always_ff @(posedge clk25) begin
        if (Reset) begin
            h_state <= ACTIVE;
        end else begin
            case (h_state)
                ACTIVE:  if (xpos == H_FP_START - 10'd1)   h_state <= FRONT;
                FRONT:   if (xpos == H_SYNC_START - 10'd1) h_state <= SYNC;
                SYNC:    if (xpos == H_BP_START - 10'd1)   h_state <= BACK;
                BACK:    if (line_end)                     h_state <= ACTIVE;
                default: h_state <= ACTIVE;
            endcase
        end
    end

    always_ff @(posedge clk25) begin
        if (Reset) begin
            v_state <= ACTIVE;
        end else if (line_end) begin
            case (v_state)
                ACTIVE:  if (ypos == V_FP_START - 10'd1)   v_state <= FRONT;
                FRONT:   if (ypos == V_SYNC_START - 10'd1) v_state <= SYNC;
                SYNC:    if (ypos == V_BP_START - 10'd1)   v_state <= BACK;
                BACK:    if (ypos == V_LAST)               v_state <= ACTIVE;
                default: v_state <= ACTIVE;
            endcase
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    logic [2:0] bar;
    assign bar = 3'(xpos / 10'd80);

    always_comb begin
        pix_red   = red;
        pix_green = green;
        pix_blue  = blue;
        if (test_sel) begin
            pix_red   = {bar[2], 2'b00};
            pix_green = {bar[1], 2'b00};
            pix_blue  = {bar[0], 1'b0};
        end
    end
`else
    logic unused_test_sel;
    assign unused_test_sel = test_sel;

    always_comb begin
        pix_red   = red;
        pix_green = green;
        pix_blue  = blue;
    end
`endif

    always_ff @(posedge clk25) begin
        if (Reset) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            vga_red     <= '0;
            vga_green   <= '0;
            vga_blue    <= '0;
            frame_tick  <= 1'b0;
            frame_count <= '0;
        end else begin
            hsync <= (h_state != SYNC);
            vsync <= (v_state != SYNC);
            if (h_state == ACTIVE && v_state == ACTIVE) begin
                vga_red   <= pix_red;
                vga_green <= pix_green;
                vga_blue  <= pix_blue;
            end else begin
                vga_red   <= '0;
                vga_green <= '0;
                vga_blue  <= '0;
            end
            frame_tick <= (xpos == '0 && ypos == V_FP_START);
            if (xpos == '0 && ypos == V_FP_START)
                frame_count <= frame_count + 8'd1;
        end
    end

endmodule
